matmul_sequencer: RTL and testbench

- Control FSM that sequences one NxN matrix multiply on the shared MAC datapath (A/B operand RAMs, 8-bit elements; C result RAM, 20-bit sums).
- Issues A/B read addresses in row/col/item order with no bubbles, and pipelines MAC enable/clear and C write strobes to match RAM and MAC latency.
- Runs one job per start handshake.
- Sits between the top-level MatrixMult wrapper and the RAM/MAC instances.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/seq_delay_line.sv | 65 ++++++
 rtl/matmul_sequencer.sv | 158 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer slice.
//   - FSM state codes (also exported on curr_st for debug)
//   - default matrix dimension, operand element and accumulator widths
//   - clog2 helper for counter widths
package matmul_pkg;

  localparam int MM_N   = 4;
  localparam int ELEM_W = 8;
  localparam int ACC_W  = 20;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Shift register carrying per-issue tags {valid, first, last, addr_c}
// from the issue stage towards the MAC and the C write port.
//   clock, rst      : clock, asynchronous active-low reset
//   flush           : synchronous clear of all valid bits (job cancel)
//   in_*            : tag of the operand pair issued this cycle
//   tap_valid/first : stage TAP, aligned with operand RAM data (MAC enable)
//   out_*           : final stage, one cycle ahead of the C write strobe
//   pending         : any tag still in flight
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int TAP   = 0,
  parameter int AW    = 9
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr,
  output logic          tap_valid,
  output logic          tap_first,
  output logic          out_valid,
  output logic          out_last,
  output logic [AW-1:0] out_addr,
  output logic          pending
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] first_q;
  logic [DEPTH-1:0] last_q;
  logic [AW-1:0]    addr_q [DEPTH];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      first_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign tap_valid = valid_q[TAP];
  assign tap_first = first_q[TAP];
  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign pending   = |valid_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM sequencing one NxN matrix multiply on the shared MAC datapath.
//   clock, rst            : clock, asynchronous active-low reset
//   start, abort          : job request (IDLE only) / cancel of running job
//   base_a/base_b/base_c  : matrix base addresses, latched on start
//   addra, addrb          : operand read addresses, one pair per ISSUE cycle
//   addrc, wrenc          : C write address and strobe
//   mac_en, mac_rst       : MAC consume / load-instead-of-accumulate
//   rows, cols, items     : issue counters r, c, k
//   busy, done, curr_st   : status, completion pulse, debug state code
//
// state    | meaning
// IDLE  0  | waiting for start
// ISSUE 1  | one operand pair per cycle, N^3 cycles
// DRAIN 2  | no issues, waiting for the final C write
// DONE  3  | one-cycle done pulse
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N         = MM_N,
  parameter int ADDR_AB_W = 10,
  parameter int ADDR_C_W  = 9,
  parameter int RD_LAT    = 1,
  parameter int MAC_LAT   = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_AB_W-1:0]  base_a,
  input  logic [ADDR_AB_W-1:0]  base_b,
  input  logic [ADDR_C_W-1:0]   base_c,
  output logic [ADDR_AB_W-1:0]  addra,
  output logic [ADDR_AB_W-1:0]  addrb,
  output logic [ADDR_C_W-1:0]   addrc,
  output logic                  wrenc,
  output logic                  mac_en,
  output logic                  mac_rst,
  output logic [clog2(N)-1:0]   rows,
  output logic [clog2(N)-1:0]   cols,
  output logic [clog2(N)-1:0]   items,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            curr_st
);

  localparam int CW = clog2(N);
  // The last delay stage is replaced by the registered wrenc/addrc pair.
  localparam int DL_DEPTH = RD_LAT + MAC_LAT - 1;

  logic [2:0]           state;
  logic [ADDR_AB_W-1:0] base_a_q, base_b_q;
  logic [ADDR_C_W-1:0]  base_c_q;
  logic [CW-1:0]        r_q, c_q, k_q;
  logic                 issuing, flush;
  logic                 tap_valid, tap_first, out_valid, out_last, pending;
  logic [ADDR_C_W-1:0]  issue_addrc, out_addr;
  logic                 wrenc_q;
  logic [ADDR_C_W-1:0]  addrc_q;

  assign issuing = (state == ST_ISSUE);
  assign flush   = abort && ((state == ST_ISSUE) || (state == ST_DRAIN));

  // N is a power of two, so r*N+k is just the concatenation {r,k}.
  assign addra       = base_a_q + ADDR_AB_W'({r_q, k_q});
  assign addrb       = base_b_q + ADDR_AB_W'({k_q, c_q});
  assign issue_addrc = base_c_q + ADDR_C_W'({r_q, c_q});

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state    <= ST_ISSUE;
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_c_q <= base_c;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            k_q <= k_q + CW'(1);
            if (&k_q) begin
              c_q <= c_q + CW'(1);
              if (&c_q) begin
                r_q <= r_q + CW'(1);
                if (&r_q) state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (abort) state <= ST_IDLE;
          else if (wrenc_q && !pending) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_delay_line #(
    .DEPTH (DL_DEPTH),
    .TAP   (RD_LAT - 1),
    .AW    (ADDR_C_W)
  ) u_delay (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (issuing),
    .in_first  (k_q == '0),
    .in_last   (&k_q),
    .in_addr   (issue_addrc),
    .tap_valid (tap_valid),
    .tap_first (tap_first),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_addr  (out_addr),
    .pending   (pending)
  );

  // addrc only moves with a write so it holds between strobes.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wrenc_q <= 1'b0;
      addrc_q <= '0;
    end else if (flush) begin
      wrenc_q <= 1'b0;
    end else begin
      wrenc_q <= out_valid && out_last;
      if (out_valid && out_last) addrc_q <= out_addr;
    end
  end

  assign wrenc   = wrenc_q;
  assign addrc   = addrc_q;
  assign mac_en  = tap_valid;
  assign mac_rst = tap_valid && tap_first;
  assign rows    = r_q;
  assign cols    = c_q;
  assign items   = k_q;
  assign busy    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign curr_st = state;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: two instances (RD_LAT/MAC_LAT = 1/1 and 3/2)
// share the stimulus. Expected per-cycle outputs come from a timeline model
// (issue index -> cycle arithmetic); C results from a RAM/MAC model are
// compared with a plain matrix product.
module tb_matmul_sequencer;

  localparam int NN    = 4;
  localparam int TOT   = NN * NN * NN;
  localparam int LIMIT = TOT + 3 + 2 + 4;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] base_a = '0;
  logic [9:0] base_b = '0;
  logic [8:0] base_c = '0;

  logic [9:0] addra_o [2];
  logic [9:0] addrb_o [2];
  logic [8:0] addrc_o [2];
  logic       wrenc_o [2];
  logic       mac_en_o [2];
  logic       mac_rst_o [2];
  logic [1:0] rows_o [2];
  logic [1:0] cols_o [2];
  logic [1:0] items_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [2:0] st_o [2];

  always #5 clock = ~clock;

  matmul_sequencer #(.N(4), .ADDR_AB_W(10), .ADDR_C_W(9), .RD_LAT(1), .MAC_LAT(1)) dut0 (
    .clock(clock), .rst(rst), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .addra(addra_o[0]), .addrb(addrb_o[0]), .addrc(addrc_o[0]), .wrenc(wrenc_o[0]),
    .mac_en(mac_en_o[0]), .mac_rst(mac_rst_o[0]),
    .rows(rows_o[0]), .cols(cols_o[0]), .items(items_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .curr_st(st_o[0]));

  matmul_sequencer #(.N(4), .ADDR_AB_W(10), .ADDR_C_W(9), .RD_LAT(3), .MAC_LAT(2)) dut1 (
    .clock(clock), .rst(rst), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .addra(addra_o[1]), .addrb(addrb_o[1]), .addrc(addrc_o[1]), .wrenc(wrenc_o[1]),
    .mac_en(mac_en_o[1]), .mac_rst(mac_rst_o[1]),
    .rows(rows_o[1]), .cols(cols_o[1]), .items(items_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .curr_st(st_o[1]));

  function automatic int rdl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int mll(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // RAM / MAC datapath model driven by the DUT strobes
  logic [7:0] amem [1024];
  logic [7:0] bmem [1024];
  logic [9:0] ha [2][3];
  logic [9:0] hb [2][3];
  int acc [2];
  int acc_d [2];
  int cval [2][512];
  int cjob [2][512];
  int job_id = 0;

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 2; j > 0; j--) begin
        ha[d][j] <= ha[d][j-1];
        hb[d][j] <= hb[d][j-1];
      end
      ha[d][0] <= addra_o[d];
      hb[d][0] <= addrb_o[d];
      if (mac_en_o[d]) begin
        if (mac_rst_o[d])
          acc[d] <= int'(amem[ha[d][rdl(d)-1]]) * int'(bmem[hb[d][rdl(d)-1]]);
        else
          acc[d] <= acc[d] + int'(amem[ha[d][rdl(d)-1]]) * int'(bmem[hb[d][rdl(d)-1]]);
      end
      acc_d[d] <= acc[d];
      if (wrenc_o[d]) begin
        cval[d][addrc_o[d]] <= (mll(d) == 1) ? acc[d] : acc_d[d];
        cjob[d][addrc_o[d]] <= job_id;
      end
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
  endtask

  typedef struct {
    int busy, mac_en, mac_rst, wrenc, addrc, done, st, issue, addra, addrb, r, c, k;
  } exp_t;

  // Cycle 1 is the first cycle after the edge that samples start.
  function automatic exp_t model(input int d, input int cy, input int ab,
                                 input int ba, input int bb, input int bc);
    exp_t e;
    int rd, ml, i, j;
    e  = '{default: 0};
    rd = rdl(d);
    ml = mll(d);
    if (ab != 0 && cy > ab) return e;
    if (cy >= 1 && cy <= TOT) begin
      i       = cy - 1;
      e.issue = 1;
      e.r     = i / (NN * NN);
      e.c     = (i / NN) % NN;
      e.k     = i % NN;
      e.addra = (ba + e.r * NN + e.k) % 1024;
      e.addrb = (bb + e.k * NN + e.c) % 1024;
    end
    j = cy - rd;
    if (j >= 1 && j <= TOT) begin
      e.mac_en  = 1;
      e.mac_rst = ((j - 1) % NN == 0) ? 1 : 0;
    end
    j = cy - rd - ml;
    if (j >= 1 && j <= TOT && (j - 1) % NN == NN - 1) begin
      e.wrenc = 1;
      e.addrc = (bc + (j - 1) / NN) % 512;
    end
    e.busy = (cy >= 1 && cy <= TOT + rd + ml) ? 1 : 0;
    e.done = (cy == TOT + rd + ml + 1) ? 1 : 0;
    e.st   = (e.done != 0) ? 3 : (e.issue != 0) ? 1 : (e.busy != 0) ? 2 : 0;
    return e;
  endfunction

  function automatic longint out_sig(input int d);
    return longint'({addra_o[d], addrb_o[d], addrc_o[d], wrenc_o[d], mac_en_o[d], mac_rst_o[d],
                     rows_o[d], cols_o[d], items_o[d], busy_o[d], done_o[d], st_o[d]});
  endfunction

  typedef struct {
    int ba, bb, bc, ab, sp, ed0, ed1, ew0, ew1;
  } vec_t;

  task automatic run_job(input vec_t v);
    int done_at [2];
    int wr_cnt [2];
    int ed [2];
    int ew [2];
    exp_t e;
    int s;
    job_id++;
    done_at = '{0, 0};
    wr_cnt  = '{0, 0};
    ed = '{v.ed0, v.ed1};
    ew = '{v.ew0, v.ew1};
    @(negedge clock);
    base_a = 10'(v.ba);
    base_b = 10'(v.bb);
    base_c = 9'(v.bc);
    start  = 1'b1;
    @(posedge clock);
    for (int cy = 1; cy <= LIMIT; cy++) begin
      @(negedge clock);
      start = (cy == v.sp);
      abort = (cy == v.ab);
      if (cy == 2) begin
        base_a = 10'($urandom);
        base_b = 10'($urandom);
        base_c = 9'($urandom);
      end
      for (int d = 0; d < 2; d++) begin
        e = model(d, cy, v.ab, v.ba, v.bb, v.bc);
        chk("busy", d, busy_o[d], e.busy);
        chk("mac_en", d, mac_en_o[d], e.mac_en);
        chk("mac_rst", d, mac_rst_o[d], e.mac_rst);
        chk("wrenc", d, wrenc_o[d], e.wrenc);
        chk("done", d, done_o[d], e.done);
        chk("curr_st", d, st_o[d], e.st);
        if (e.wrenc != 0) chk("addrc", d, addrc_o[d], e.addrc);
        if (e.issue != 0) begin
          chk("addra", d, addra_o[d], e.addra);
          chk("addrb", d, addrb_o[d], e.addrb);
          chk("rck", d, {rows_o[d], cols_o[d], items_o[d]}, e.r * 16 + e.c * 4 + e.k);
        end
        if (done_o[d] && done_at[d] == 0) done_at[d] = cy;
        if (wrenc_o[d]) wr_cnt[d]++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("done_cycle", d, done_at[d], ed[d]);
      chk("wrenc_count", d, wr_cnt[d], ew[d]);
      if (v.ab == 0) begin
        for (int i = 0; i < NN; i++) begin
          for (int j = 0; j < NN; j++) begin
            s = 0;
            for (int k = 0; k < NN; k++)
              s += int'(amem[(v.ba + i * NN + k) % 1024]) * int'(bmem[(v.bb + k * NN + j) % 1024]);
            chk("c_elem", d,
                (cjob[d][(v.bc + i * NN + j) % 512] == job_id) ? cval[d][(v.bc + i * NN + j) % 512] : -1,
                s);
          end
        end
      end
    end
  endtask

  vec_t vecs [6];

  initial begin
    int a;
    for (int i = 0; i < 1024; i++) begin
      amem[i] = 8'($urandom);
      bmem[i] = 8'($urandom);
    end
    for (int i = 0; i < 16; i++) begin
      amem[i]      = 8'(i);
      bmem[64 + i] = 8'(10 + i);
    end

    vecs[0] = '{ba: 0,    bb: 64, bc: 0,   ab: 0,  sp: 0,  ed0: 67, ed1: 70, ew0: 16, ew1: 16};
    vecs[1] = '{ba: 1020, bb: 64, bc: 100, ab: 0,  sp: 20, ed0: 67, ed1: 70, ew0: 16, ew1: 16};
    vecs[2] = '{ba: 0,    bb: 64, bc: 0,   ab: 30, sp: 0,  ed0: 0,  ed1: 0,  ew0: 7,  ew1: 6};
    for (int n = 3; n < 6; n++) begin
      vecs[n].ba = int'($urandom_range(1023, 0));
      vecs[n].bb = int'($urandom_range(1023, 0));
      vecs[n].bc = int'($urandom_range(511, 0));
      vecs[n].sp = 0;
      vecs[n].ab = (n == 5) ? int'($urandom_range(60, 10)) : 0;
      if (vecs[n].ab == 0) begin
        vecs[n].ed0 = TOT + rdl(0) + mll(0) + 1;
        vecs[n].ed1 = TOT + rdl(1) + mll(1) + 1;
        vecs[n].ew0 = TOT / NN;
        vecs[n].ew1 = TOT / NN;
      end else begin
        vecs[n].ed0 = 0;
        vecs[n].ed1 = 0;
        vecs[n].ew0 = 0;
        vecs[n].ew1 = 0;
        for (int g = 0; g < TOT / NN; g++) begin
          if (NN * g + NN + rdl(0) + mll(0) <= vecs[n].ab) vecs[n].ew0++;
          if (NN * g + NN + rdl(1) + mll(1) <= vecs[n].ab) vecs[n].ew1++;
        end
      end
    end

    // reset state
    #1;
    for (int d = 0; d < 2; d++) chk("reset_outputs", d, out_sig(d), 0);
    @(negedge clock);
    @(negedge clock);
    rst = 1'b1;

    for (int n = 0; n < 6; n++) begin
      run_job(vecs[n]);
      if (n == 0) begin
        for (int d = 0; d < 2; d++) begin
          chk("c00", d, cval[d][0], 116);
          chk("c33", d, cval[d][15], 1046);
        end
      end
    end

    // abort together with start in IDLE: no job
    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_start_st", d, st_o[d], 0);
      chk("abort_start_busy", d, busy_o[d], 0);
    end

    // start held high: back-to-back jobs with one IDLE cycle between
    @(negedge clock);
    base_a = 10'd0;
    base_b = 10'd64;
    base_c = 9'd0;
    start  = 1'b1;
    @(posedge clock);
    for (int cy = 1; cy <= 76; cy++) begin
      @(negedge clock);
      if (cy == 67) chk("b2b_done", 0, st_o[0], 3);
      if (cy == 68) chk("b2b_idle", 0, st_o[0], 0);
      if (cy == 69) chk("b2b_issue", 0, st_o[0], 1);
      if (cy == 70) chk("b2b_done", 1, st_o[1], 3);
      if (cy == 71) chk("b2b_idle", 1, st_o[1], 0);
      if (cy == 72) chk("b2b_issue", 1, st_o[1], 1);
      if (cy >= 75) begin
        for (int d = 0; d < 2; d++) chk("b2b_abort_st", d, st_o[d], 0);
      end
      start = (cy < 74);
      abort = (cy == 74);
    end
    start = 1'b0;
    abort = 1'b0;

    // asynchronous reset mid-job, with an ignored start pulse first
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int cy = 1; cy <= 20; cy++) begin
      @(negedge clock);
      start = (cy == 10);
      if (cy == 11 || cy == 12) begin
        for (int d = 0; d < 2; d++) begin
          chk("start_busy_ignored", d, busy_o[d], 1);
          a = (cy == 12) ? 11 : 10;
          chk("start_busy_items", d, {rows_o[d], cols_o[d], items_o[d]}, a);
        end
      end
    end
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("midjob_reset_outputs", d, out_sig(d), 0);
    @(negedge clock);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("post_reset_st", d, st_o[d], 0);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_st2", d, st_o[d], 0);
      chk("post_reset_busy", d, busy_o[d], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
